iob_reset_seq: RTL

Multi-channel reset sequencer for FPGA top levels. Holds every downstream reset domain (system core, Ethernet, DDR-side AXI, and so on) in reset for a minimum duration, then waits for a stable clock-lock indication. It then releases the domains one at a time, in index order, gated by per-channel ready inputs (for example DDR calibration done). It is the parametrised successor of the fixed power-on pulse generator: it adds N channels, lock debouncing, lock-loss re-sequencing, software restart and ready-wait timeout reporting.

---
 rtl/iob_reset_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/iob_reset_seq.sv
// Multi-channel reset sequencer: hold all domains, debounce PLL lock, then release
// channels in index order gated by per-channel ready, with lock-loss and restart handling.
module iob_reset_seq #(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned DURATION = 10,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned GAP      = 5,
    parameter int unsigned TIMEOUT  = 20,
    parameter int unsigned CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic            locked,
    input  logic [N_CH-1:0] ready_i,
    output logic [N_CH-1:0] rst_o,
    output logic            done_o,
    output logic            timeout_o,
    output logic [7:0]      lock_loss_cnt_o
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] DUR_LAST  = CNT_W'(DURATION - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [CH_W-1:0]  CH_ONE    = CH_W'(1);

    typedef enum logic [2:0] {
        StHold,
        StWaitLock,
        StSeqWait,
        StSeqGap,
        StDone
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CH_W-1:0]  ch_q;
    logic             lock_lost;

    // Lock drops only matter once sequencing has begun; WAIT_LOCK handles its own debounce.
    assign lock_lost = !locked &&
                       ((state_q == StSeqWait) || (state_q == StSeqGap) || (state_q == StDone));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StHold;
            cnt_q           <= '0;
            ch_q            <= '0;
            rst_o           <= '1;
            done_o          <= 1'b0;
            timeout_o       <= 1'b0;
            lock_loss_cnt_o <= '0;
        end else if (restart) begin
            state_q   <= StHold;
            cnt_q     <= '0;
            ch_q      <= '0;
            rst_o     <= '1;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else if (lock_lost) begin
            state_q <= StHold;
            cnt_q   <= '0;
            ch_q    <= '0;
            rst_o   <= '1;
            done_o  <= 1'b0;
            if (lock_loss_cnt_o != 8'hff) begin
                lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
            end
        end else begin
            case (state_q)
                StHold: begin
                    rst_o <= '1;
                    if (cnt_q == DUR_LAST) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                StWaitLock: begin
                    if (!locked) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_q <= StSeqWait;
                        cnt_q   <= '0;
                        ch_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                StSeqWait: begin
                    if (ready_i[ch_q]) begin
                        rst_o[ch_q] <= 1'b0;
                        cnt_q       <= '0;
                        if (ch_q == CH_LAST) begin
                            state_q <= StDone;
                            done_o  <= 1'b1;
                        end else if (GAP == 0) begin
                            ch_q <= ch_q + CH_ONE;
                        end else begin
                            state_q <= StSeqGap;
                        end
                    end else begin
                        // Saturate so the wait length stays observable without wrapping.
                        if (cnt_q != TMO) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                        if ((cnt_q == TMO) || (cnt_q + CNT_ONE == TMO)) begin
                            timeout_o <= 1'b1;
                        end
                    end
                end
                StSeqGap: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= StSeqWait;
                        cnt_q   <= '0;
                        ch_q    <= ch_q + CH_ONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_q <= StHold;
                    cnt_q   <= '0;
                    ch_q    <= '0;
                    rst_o   <= '1;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
